axil_write_slave: RTL and testbench
===================================

# axil_write_slave

Parametrised AXI4-Lite write-channel slave for the CL register/abstraction layer. Accepts AW and W independently and in either order, decodes the address against a configurable window and issues one write to a backend register port via a valid/ready handshake. Returns a B response carrying OKAY, SLVERR (backend error) or DECERR (address out of window). Supersedes the single-bit, AW-only write-request tracker with full AW/W/B handling, strobes and error responses.

## Interface
Parameters:
- ADDR_W, 32, AXI address width
- DATA_W, 32, AXI data width; 32 or 64 only
- BASE_ADDR, 0, first byte address of the decoded window
- SPAN, 4096, window size in bytes; nonzero multiple of DATA_W/8

Ports:
- clk  in  1  clock
- r_reset  in  1  reset, synchronous, active-low
- awaddr  in  ADDR_W  write address
- awvalid / awready  in / out  1  AW handshake
- wdata  in  DATA_W  write data
- wstrb  in  DATA_W/8  byte strobes
- wvalid / wready  in / out  1  W handshake
- bresp  out  2  write response
- bvalid / bready  out / in  1  B handshake
- wr_valid / wr_ready  out / in  1  backend write handshake
- wr_addr  out  ADDR_W  byte offset from BASE_ADDR, low log2(DATA_W/8) bits forced to 0
- wr_data  out  DATA_W  write data
- wr_strb  out  DATA_W/8  byte strobes
- wr_err  in  1  backend error, sampled with wr_valid && wr_ready

## Operation
- Reset (r_reset=0 at a clk edge) sets: state IDLE, both hold flags clear, awready=0, wready=0, bvalid=0, bresp=2'b00, wr_valid=0, wr_addr/wr_data/wr_strb=0. Reset mid-transaction discards held AW/W data and drops bvalid/wr_valid without completing a handshake.
- Outputs come from registers; no combinational path from any input to any output.
- IDLE: awready=1 iff AW not held; wready=1 iff W not held. An AW or W handshake latches the payload and sets the corresponding hold flag. AW and W may arrive in the same cycle or in either order, with any gap between them.
- When both flags are set, compute the range check off = awaddr − BASE_ADDR (unsigned, ADDR_W bits); in range iff off < SPAN. An address below BASE_ADDR wraps to a large value and fails the check.
- In range: go to ISSUE with wr_valid=1 and wr_addr/wr_data/wr_strb driven.
- Out of range: go to RESP with bresp=DECERR (2'b11). No backend write is issued.
- ISSUE: hold wr_valid and its payload stable until wr_ready. On the handshake, bresp = wr_err ? SLVERR (2'b10) : OKAY (2'b00). Go to RESP.
- RESP: bvalid=1 and bresp stable until bready. On the handshake, clear both hold flags and return to IDLE.
- awready and wready are 0 in ISSUE and RESP. Only one transaction is outstanding at a time.
- wstrb=0 is still issued to the backend (with wr_strb=0) and gets a normal response.
- awprot is not implemented.

## Timing
- AW and W handshakes both complete at edge N: wr_valid=1 from N+1.
- wr_ready=1 at N+1: bvalid=1 from N+2. awready and wready return to 1 the cycle after the B handshake.
- DECERR path: handshakes at edge N give bvalid=1 from N+1.
- AW at edge N and W at edge N+k: awready=0 from N+1 until the transaction completes; wr_valid=1 from N+k+1.
- Minimum throughput: one write per 4 cycles, with back-to-back valids and wr_ready/bready tied high.

## Structure
- Package axil_pkg holds:
  - typedef axil_resp_t (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11)
  - typedef wr_state_t (IDLE, ISSUE, RESP)
- Sub-module axil_hold_reg, parametrised by payload width: one-entry holding register with ready/valid input, a full flag and a clear input. It is instantiated twice, once for AW (ADDR_W bits) and once for W (DATA_W + DATA_W/8 bits).
- The FSM and range decode live in the top module.

## Test plan
- AW 0x10 and W 0xDEADBEEF/strb 0xF in the same cycle; wr_ready=1, bready=1 -> wr_valid at N+1 with wr_addr=0x10, wr_data=0xDEADBEEF; bvalid at N+2, bresp=2'b00.
- W first, AW 3 cycles later at 0x24 -> wready=0 after the W handshake; wr_valid the cycle after AW, wr_addr=0x24, bresp=OKAY.
- AW 0x2000 with BASE_ADDR=0, SPAN=4096 -> no wr_valid at any point; bvalid the next cycle with bresp=2'b11.
- wr_ready held low 5 cycles, then high with wr_err=1 -> wr_valid and its payload stable for all 6 cycles; bresp=2'b10.
- bready low 4 cycles -> bvalid and bresp stable, awready/wready stay 0; a second AW offered during this is accepted only after the B handshake.
- r_reset=0 asserted while in ISSUE -> next cycle wr_valid=0, bvalid=0, awready=0; after release, a new write completes with OKAY and no stale data.

Source files
------------

// File: rtl/axil_pkg.sv
// axil_pkg: shared types for the AXI4-Lite write slave.
//   axil_resp_t : AXI B-channel response codes
//   wr_state_t  : write-transaction sequencing states
//   addr_lsb()  : number of byte-offset address bits for a given data width
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axil_resp_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } wr_state_t;

  function automatic int addr_lsb(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/axil_hold_reg.sv
// axil_hold_reg: one-entry holding register with a registered ready.
// Ports:
//   clk, r_reset          clock, synchronous active-low reset
//   accept_en             owner allows acceptance in the next cycle
//   clear                 drop the held entry (transaction finished)
//   in_valid / in_ready   input handshake (in_ready is a flop)
//   in_data               payload captured on the handshake
//   full                  an entry is held
//   data                  held payload
module axil_hold_reg
  import axil_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             r_reset,
  input  logic             accept_en,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  logic             full_q, full_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (clear) begin
      full_d = 1'b0;
    end else if (in_valid && ready_q) begin
      full_d = 1'b1;
      data_d = in_data;
    end
    // Ready is computed from the next full value so it drops on the very
    // edge that captures the payload; a second beat can never be accepted.
    ready_d = accept_en && !full_d;
  end

  always_ff @(posedge clk) begin
    if (!r_reset) begin
      full_q  <= 1'b0;
      ready_q <= 1'b0;
      data_q  <= '0;
    end else begin
      full_q  <= full_d;
      ready_q <= ready_d;
      data_q  <= data_d;
    end
  end

  assign in_ready = ready_q;
  assign full     = full_q;
  assign data     = data_q;

endmodule

// File: rtl/axil_write_slave.sv
// axil_write_slave: AXI4-Lite write-channel slave feeding a backend
// register write port.
// Ports:
//   clk, r_reset                clock, synchronous active-low reset
//   awaddr/awvalid/awready      AXI write address channel
//   wdata/wstrb/wvalid/wready   AXI write data channel
//   bresp/bvalid/bready         AXI write response channel
//   wr_valid/wr_ready           backend write handshake
//   wr_addr/wr_data/wr_strb     backend write payload (wr_addr is the
//                               word-aligned byte offset from BASE_ADDR)
//   wr_err                      backend error, sampled on the handshake
// AW and W are captured independently; once both are held the address is
// range-checked and either a backend write or a DECERR response follows.
// All outputs are driven directly from flops.
module axil_write_slave
  import axil_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       SPAN      = 4096
) (
  input  logic                  clk,
  input  logic                  r_reset,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W/8-1:0]   wr_strb,
  input  logic                  wr_err
);

  localparam int              STRB_W   = DATA_W / 8;
  localparam int              LSB      = addr_lsb(DATA_W);
  // One extra bit so a SPAN equal to 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] SPAN_EXT = (ADDR_W + 1)'(SPAN);

  wr_state_t            state_q, state_d;
  axil_resp_t           bresp_q, bresp_d;
  logic                 bvalid_q, bvalid_d;
  logic                 wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]    wr_data_q, wr_data_d;
  logic [STRB_W-1:0]    wr_strb_q, wr_strb_d;

  logic                 accept_en;
  logic                 hold_clear;
  logic                 aw_full, w_full;
  logic [ADDR_W-1:0]    aw_addr;
  logic [DATA_W+STRB_W-1:0] w_payload;
  logic [ADDR_W-1:0]    off;
  logic                 in_window;

  axil_hold_reg #(.WIDTH(ADDR_W)) u_aw_hold (
    .clk      (clk),
    .r_reset  (r_reset),
    .accept_en(accept_en),
    .clear    (hold_clear),
    .in_valid (awvalid),
    .in_ready (awready),
    .in_data  (awaddr),
    .full     (aw_full),
    .data     (aw_addr)
  );

  axil_hold_reg #(.WIDTH(DATA_W + STRB_W)) u_w_hold (
    .clk      (clk),
    .r_reset  (r_reset),
    .accept_en(accept_en),
    .clear    (hold_clear),
    .in_valid (wvalid),
    .in_ready (wready),
    .in_data  ({wstrb, wdata}),
    .full     (w_full),
    .data     (w_payload)
  );

  // Unsigned subtraction: addresses below BASE_ADDR wrap to a large offset
  // and therefore fall outside the window.
  assign off       = aw_addr - BASE_ADDR;
  assign in_window = ({1'b0, off} < SPAN_EXT);

  always_comb begin
    state_d    = state_q;
    bresp_d    = bresp_q;
    bvalid_d   = bvalid_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_strb_d  = wr_strb_q;
    hold_clear = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (aw_full && w_full) begin
          if (in_window) begin
            state_d    = ISSUE;
            wr_valid_d = 1'b1;
            wr_addr_d  = {off[ADDR_W-1:LSB], {LSB{1'b0}}};
            wr_data_d  = w_payload[DATA_W-1:0];
            wr_strb_d  = w_payload[DATA_W +: STRB_W];
          end else begin
            state_d  = RESP;
            bvalid_d = 1'b1;
            bresp_d  = DECERR;
          end
        end
      end
      ISSUE: begin
        if (wr_ready) begin
          state_d    = RESP;
          wr_valid_d = 1'b0;
          bvalid_d   = 1'b1;
          bresp_d    = wr_err ? SLVERR : OKAY;
        end
      end
      RESP: begin
        if (bready) begin
          state_d    = IDLE;
          bvalid_d   = 1'b0;
          hold_clear = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Channels reopen only once the FSM is (or is about to be) idle, which
    // keeps a single transaction outstanding.
    accept_en = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!r_reset) begin
      state_q    <= IDLE;
      bresp_q    <= OKAY;
      bvalid_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
    end else begin
      state_q    <= state_d;
      bresp_q    <= bresp_d;
      bvalid_q   <= bvalid_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_strb_q  <= wr_strb_d;
    end
  end

  assign bresp    = bresp_q;
  assign bvalid   = bvalid_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_strb  = wr_strb_q;

endmodule

// File: tb/tb_axil_write_slave.sv
// Testbench for axil_write_slave (ADDR_W=32, DATA_W=32, BASE_ADDR=0,
// SPAN=4096). Directed scenarios plus a randomized sweep checked against a
// reference model of the address window and response rules.
module tb_axil_write_slave;

  localparam int          ADDR_W = 32;
  localparam int          DATA_W = 32;
  localparam logic [31:0] BASE   = 32'h0;
  localparam int unsigned SPAN   = 4096;

  logic        clk = 1'b0;
  logic        r_reset;
  logic [31:0] awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;
  logic        wr_err;

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  axil_write_slave #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE), .SPAN(SPAN)
  ) dut (
    .clk(clk), .r_reset(r_reset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_err(wr_err)
  );

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer an AW beat; returns after the edge on which it was accepted.
  task automatic offer_aw(input logic [31:0] a);
    bit ok = 0;
    awaddr  = a;
    awvalid = 1'b1;
    for (int c = 0; c < 40 && !ok; c++) begin
      if (awready) ok = 1;
      tick();
    end
    awvalid = 1'b0;
    cmp_cnt++;
    if (!ok) begin
      err_cnt++;
      $display("FAIL aw_accept_timeout: awready got 0 expected 1 (addr %h)", a);
    end
  endtask

  task automatic offer_w(input logic [31:0] d, input logic [3:0] s);
    bit ok = 0;
    wdata  = d;
    wstrb  = s;
    wvalid = 1'b1;
    for (int c = 0; c < 40 && !ok; c++) begin
      if (wready) ok = 1;
      tick();
    end
    wvalid = 1'b0;
    cmp_cnt++;
    if (!ok) begin
      err_cnt++;
      $display("FAIL w_accept_timeout: wready got 0 expected 1 (data %h)", d);
    end
  endtask

  // Offer AW and W together; returns after the shared acceptance edge.
  task automatic offer_both(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
    bit ok = 0;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    for (int c = 0; c < 40 && !ok; c++) begin
      if (awready && wready) ok = 1;
      tick();
    end
    awvalid = 1'b0; wvalid = 1'b0;
    cmp_cnt++;
    if (!ok) begin
      err_cnt++;
      $display("FAIL both_accept_timeout: aw/w ready got %b%b expected 11", awready, wready);
    end
  endtask

  task automatic test_reset();
    r_reset = 1'b0;
    awvalid = 0; wvalid = 0; bready = 0; wr_ready = 0; wr_err = 0;
    awaddr = 0; wdata = 0; wstrb = 0;
    tick(); tick();
    cmp_cnt++;
    if ({awready, wready, bvalid, bresp, wr_valid} !== 6'b0) begin
      err_cnt++;
      $display("FAIL reset_ctrl: {awready,wready,bvalid,bresp,wr_valid} got %b expected 000000",
               {awready, wready, bvalid, bresp, wr_valid});
    end
    cmp_cnt++;
    if ({wr_addr, wr_data, wr_strb} !== 68'h0) begin
      err_cnt++;
      $display("FAIL reset_payload: addr/data/strb got %h/%h/%h expected 0", wr_addr, wr_data, wr_strb);
    end
    r_reset = 1'b1;
    tick();
    cmp_cnt++;
    if ({awready, wready} !== 2'b11) begin
      err_cnt++;
      $display("FAIL reset_release_ready: aw/w ready got %b expected 11", {awready, wready});
    end
  endtask

  task automatic test_same_cycle();
    wr_ready = 1'b1; bready = 1'b1;
    offer_both(32'h10, 32'hDEADBEEF, 4'hF);
    cmp_cnt++;
    if ({wr_valid, awready, wready} !== 3'b000) begin
      err_cnt++;
      $display("FAIL same_after_hs: wr_valid/awready/wready got %b expected 000", {wr_valid, awready, wready});
    end
    tick();
    cmp_cnt++;
    if (wr_valid !== 1'b1 || wr_addr !== 32'h10 || wr_data !== 32'hDEADBEEF || wr_strb !== 4'hF) begin
      err_cnt++;
      $display("FAIL same_issue: v=%b a=%h d=%h s=%h expected v=1 a=10 d=deadbeef s=f",
               wr_valid, wr_addr, wr_data, wr_strb);
    end
    tick();
    cmp_cnt++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || wr_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL same_resp: bvalid=%b bresp=%b wr_valid=%b expected 1 00 0", bvalid, bresp, wr_valid);
    end
    tick();
    cmp_cnt++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
      err_cnt++;
      $display("FAIL same_done: bvalid=%b awready=%b wready=%b expected 0 1 1", bvalid, awready, wready);
    end
    wr_ready = 1'b0; bready = 1'b0;
  endtask

  task automatic test_w_first();
    wr_ready = 1'b1; bready = 1'b1;
    offer_w(32'hCAFE0001, 4'h5);
    cmp_cnt++;
    if (wready !== 1'b0 || awready !== 1'b1) begin
      err_cnt++;
      $display("FAIL wfirst_ready: wready=%b awready=%b expected 0 1", wready, awready);
    end
    for (int i = 0; i < 3; i++) begin
      cmp_cnt++;
      if (wr_valid !== 1'b0) begin
        err_cnt++;
        $display("FAIL wfirst_early_issue: wr_valid got %b expected 0", wr_valid);
      end
      tick();
    end
    offer_aw(32'h24);
    cmp_cnt++;
    if (wr_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL wfirst_latency: wr_valid got %b expected 0 at aw edge", wr_valid);
    end
    tick();
    cmp_cnt++;
    if (wr_valid !== 1'b1 || wr_addr !== 32'h24 || wr_data !== 32'hCAFE0001 || wr_strb !== 4'h5) begin
      err_cnt++;
      $display("FAIL wfirst_issue: v=%b a=%h d=%h s=%h expected 1 24 cafe0001 5",
               wr_valid, wr_addr, wr_data, wr_strb);
    end
    tick();
    cmp_cnt++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      err_cnt++;
      $display("FAIL wfirst_resp: bvalid=%b bresp=%b expected 1 00", bvalid, bresp);
    end
    tick();
    wr_ready = 1'b0; bready = 1'b0;
  endtask

  task automatic test_decerr();
    wr_ready = 1'b1; bready = 1'b0;
    offer_both(32'h2000, 32'h12345678, 4'hF);
    cmp_cnt++;
    if (wr_valid !== 1'b0 || bvalid !== 1'b0) begin
      err_cnt++;
      $display("FAIL decerr_early: wr_valid=%b bvalid=%b expected 0 0", wr_valid, bvalid);
    end
    tick();
    cmp_cnt++;
    if (bvalid !== 1'b1 || bresp !== 2'b11 || wr_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL decerr_resp: bvalid=%b bresp=%b wr_valid=%b expected 1 11 0", bvalid, bresp, wr_valid);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    cmp_cnt++;
    if (bvalid !== 1'b0 || wr_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL decerr_done: bvalid=%b wr_valid=%b expected 0 0", bvalid, wr_valid);
    end
    wr_ready = 1'b0;
  endtask

  // wr_ready low for 5 cycles, then high with wr_err; strobe 0 still issues.
  task automatic test_backpressure();
    wr_ready = 1'b0; bready = 1'b0; wr_err = 1'b0;
    offer_both(32'h30, 32'hA5A5A5A5, 4'h0);
    tick();
    for (int i = 0; i < 6; i++) begin
      cmp_cnt++;
      if (wr_valid !== 1'b1 || wr_addr !== 32'h30 || wr_data !== 32'hA5A5A5A5 || wr_strb !== 4'h0) begin
        err_cnt++;
        $display("FAIL bp_stable[%0d]: v=%b a=%h d=%h s=%h expected 1 30 a5a5a5a5 0",
                 i, wr_valid, wr_addr, wr_data, wr_strb);
      end
      if (i == 5) begin
        wr_ready = 1'b1; wr_err = 1'b1;
      end
      tick();
    end
    wr_ready = 1'b0; wr_err = 1'b0;
    cmp_cnt++;
    if (bvalid !== 1'b1 || bresp !== 2'b10 || wr_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL bp_slverr: bvalid=%b bresp=%b wr_valid=%b expected 1 10 0", bvalid, bresp, wr_valid);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic test_bready_stall();
    wr_ready = 1'b1; bready = 1'b0;
    offer_both(32'h50, 32'h0BADF00D, 4'hC);
    tick(); tick();
    wr_ready = 1'b0;
    awaddr = 32'h64; awvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmp_cnt++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
        err_cnt++;
        $display("FAIL bstall[%0d]: bvalid=%b bresp=%b awready=%b wready=%b expected 1 00 0 0",
                 i, bvalid, bresp, awready, wready);
      end
      tick();
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    cmp_cnt++;
    if (bvalid !== 1'b0 || awready !== 1'b1) begin
      err_cnt++;
      $display("FAIL bstall_reopen: bvalid=%b awready=%b expected 0 1", bvalid, awready);
    end
    tick();
    awvalid = 1'b0;
    cmp_cnt++;
    if (awready !== 1'b0 || wready !== 1'b1) begin
      err_cnt++;
      $display("FAIL bstall_second_aw: awready=%b wready=%b expected 0 1", awready, wready);
    end
    offer_w(32'h77770000, 4'hF);
    tick();
    cmp_cnt++;
    if (wr_valid !== 1'b1 || wr_addr !== 32'h64 || wr_data !== 32'h77770000) begin
      err_cnt++;
      $display("FAIL bstall_second_issue: v=%b a=%h d=%h expected 1 64 77770000", wr_valid, wr_addr, wr_data);
    end
    wr_ready = 1'b1; tick(); wr_ready = 1'b0;
    bready = 1'b1; tick(); bready = 1'b0;
  endtask

  task automatic test_reset_mid();
    wr_ready = 1'b0; bready = 1'b0;
    offer_both(32'h80, 32'h11111111, 4'hF);
    tick();
    cmp_cnt++;
    if (wr_valid !== 1'b1) begin
      err_cnt++;
      $display("FAIL rstmid_issue: wr_valid got %b expected 1", wr_valid);
    end
    r_reset = 1'b0;
    tick();
    cmp_cnt++;
    if ({wr_valid, bvalid, awready, wready} !== 4'b0000) begin
      err_cnt++;
      $display("FAIL rstmid_clear: wr_valid/bvalid/awready/wready got %b expected 0000",
               {wr_valid, bvalid, awready, wready});
    end
    r_reset = 1'b1;
    tick();
    offer_aw(32'h44);
    for (int i = 0; i < 2; i++) begin
      cmp_cnt++;
      if (wr_valid !== 1'b0) begin
        err_cnt++;
        $display("FAIL rstmid_stale_w: wr_valid got %b expected 0", wr_valid);
      end
      tick();
    end
    offer_w(32'h22222222, 4'h3);
    tick();
    cmp_cnt++;
    if (wr_valid !== 1'b1 || wr_addr !== 32'h44 || wr_data !== 32'h22222222 || wr_strb !== 4'h3) begin
      err_cnt++;
      $display("FAIL rstmid_new: v=%b a=%h d=%h s=%h expected 1 44 22222222 3",
               wr_valid, wr_addr, wr_data, wr_strb);
    end
    wr_ready = 1'b1; tick(); wr_ready = 1'b0;
    cmp_cnt++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      err_cnt++;
      $display("FAIL rstmid_resp: bvalid=%b bresp=%b expected 1 00", bvalid, bresp);
    end
    bready = 1'b1; tick(); bready = 1'b0;
  endtask

  // Valids held high with wr_ready/bready tied high: B handshakes must be
  // no more than 4 cycles apart.
  task automatic test_back_to_back();
    int hs[$];
    wr_ready = 1'b1; bready = 1'b1;
    awaddr = 32'h100; wdata = 32'h5A5A0000; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (bvalid) hs.push_back(c);
      tick();
    end
    awvalid = 1'b0; wvalid = 1'b0;
    repeat (6) tick();
    wr_ready = 1'b0; bready = 1'b0;
    cmp_cnt++;
    if (hs.size() < 6) begin
      err_cnt++;
      $display("FAIL b2b_count: B handshakes got %0d expected >= 6", hs.size());
    end
    for (int i = 1; i < hs.size(); i++) begin
      cmp_cnt++;
      if (hs[i] - hs[i-1] > 4) begin
        err_cnt++;
        $display("FAIL b2b_interval[%0d]: gap got %0d expected <= 4", i, hs[i] - hs[i-1]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a, d, off, exp_addr;
      logic [3:0]  s;
      logic [1:0]  exp_resp;
      bit          exp_in, err_bit, saw_wr, saw_b, done;
      int          gap, wr_wait, b_wait;
      case ($urandom_range(0, 3))
        0, 1:    a = BASE + $urandom_range(0, SPAN - 1);
        2:       a = BASE + SPAN + $urandom_range(0, 8191);
        default: a = 32'hFFFF_FF00 + $urandom_range(0, 255);
      endcase
      d       = $urandom;
      s       = 4'($urandom_range(0, 15));
      gap     = $urandom_range(0, 3);
      wr_wait = $urandom_range(0, 3);
      b_wait  = $urandom_range(0, 3);
      err_bit = 1'($urandom_range(0, 1));
      off      = a - BASE;
      exp_in   = (off < SPAN);
      exp_addr = off - (off % 4);
      exp_resp = !exp_in ? 2'b11 : (err_bit ? 2'b10 : 2'b00);

      wr_ready = 1'b0; bready = 1'b0;
      if (gap == 0) begin
        offer_both(a, d, s);
      end else if ($urandom_range(0, 1) == 1) begin
        offer_aw(a); repeat (gap - 1) tick(); offer_w(d, s);
      end else begin
        offer_w(d, s); repeat (gap - 1) tick(); offer_aw(a);
      end

      saw_wr = 0; saw_b = 0; done = 0;
      for (int c = 0; c < 60 && !done; c++) begin
        wr_ready = 1'b0; bready = 1'b0; wr_err = ~err_bit;
        if (wr_valid) begin
          if (!saw_wr) begin
            saw_wr = 1;
            cmp_cnt++;
            if (!exp_in || wr_addr !== exp_addr || wr_data !== d || wr_strb !== s) begin
              err_cnt++;
              $display("FAIL rand_issue[%0d]: a=%h d=%h s=%h expected in=%b a=%h d=%h s=%h",
                       n, wr_addr, wr_data, wr_strb, exp_in, exp_addr, d, s);
            end
          end
          if (wr_wait == 0) begin
            wr_ready = 1'b1; wr_err = err_bit;
          end else begin
            wr_wait--;
          end
        end
        if (bvalid) begin
          if (!saw_b) begin
            saw_b = 1;
            cmp_cnt++;
            if (bresp !== exp_resp) begin
              err_cnt++;
              $display("FAIL rand_bresp[%0d]: bresp got %b expected %b (addr %h)", n, bresp, exp_resp, a);
            end
          end
          if (b_wait == 0) begin
            bready = 1'b1; done = 1;
          end else begin
            b_wait--;
          end
        end
        tick();
      end
      wr_ready = 1'b0; bready = 1'b0; wr_err = 1'b0;
      cmp_cnt++;
      if (!done || saw_wr != exp_in) begin
        err_cnt++;
        $display("FAIL rand_complete[%0d]: done=%b issued=%b expected done=1 issued=%b", n, done, saw_wr, exp_in);
      end
    end
  endtask

  initial begin
    test_reset();
    test_same_cycle();
    test_w_first();
    test_decerr();
    test_backpressure();
    test_bready_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
